// File: rtl/uart_echo_responder.sv
// Host-side echo engine for UART_MIKE: drains rx bytes, drops parity
// errors, queues good bytes and retransmits them with a fixed gap.
`timescale 1ns/1ps
module uart_echo_responder #(
  parameter int UART_DATA_WIDTH = 8,
  parameter int DATA_WIDTH      = UART_DATA_WIDTH,
  parameter int FIFO_DEPTH      = 4,
  parameter int SEND_PULSE      = 2,
  parameter int TX_GAP_CYCLES   = 60,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          enable,
  input  logic                          rx_flag,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          parity_error,
  output logic                          rx_flag_clr,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_send,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          err_count,
  output logic [CNT_WIDTH-1:0]          drop_count
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int TMAX = (SEND_PULSE > TX_GAP_CYCLES) ?
                        SEND_PULSE : TX_GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] SEND_LAST = TW'(SEND_PULSE - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(TX_GAP_CYCLES - 1);

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_CLR  = 1'b1;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_SEND = 2'd1;
  localparam logic [1:0] T_GAP  = 2'd2;

  logic [0:0]            c_state;
  logic [1:0]            t_state;
  logic [TW-1:0]         tcnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic take;
  logic push;
  logic pop;
  logic gap_done;

  assign take     = (c_state == C_IDLE) && rx_flag;
  assign push     = take && !parity_error && (fifo_count != FULL);
  assign gap_done = (t_state == T_GAP) && (tcnt == GAP_LAST);
  // The last gap cycle may pop directly, giving SEND_PULSE+GAP spacing.
  assign pop      = enable && (fifo_count != '0) &&
                    ((t_state == T_IDLE) || gap_done);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      c_state     <= C_IDLE;
      t_state     <= T_IDLE;
      tcnt        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_flag_clr <= 1'b0;
      tx_data     <= '0;
      tx_send     <= 1'b0;
      fifo_count  <= '0;
      err_count   <= '0;
      drop_count  <= '0;
    end else begin
      unique case (c_state)
        C_IDLE: begin
          if (rx_flag) begin
            c_state     <= C_CLR;
            rx_flag_clr <= 1'b1;
            if (parity_error) begin
              if (err_count != '1) err_count <= err_count + 1'b1;
            end else if (fifo_count == FULL) begin
              if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
          end
        end
        C_CLR: begin
          if (!rx_flag) begin
            c_state     <= C_IDLE;
            rx_flag_clr <= 1'b0;
          end
        end
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase

      if (pop) begin
        t_state <= T_SEND;
        tx_send <= 1'b1;
        tcnt    <= '0;
      end else begin
        case (t_state)
          T_SEND: begin
            if (tcnt == SEND_LAST) begin
              tx_send <= 1'b0;
              t_state <= T_GAP;
              tcnt    <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          T_GAP: begin
            if (gap_done) t_state <= T_IDLE;
            else          tcnt    <= tcnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder: capture, parity drop,
// overflow, sticky flag, push/pop overlap and reset mid-send.
`timescale 1ns/1ps
module tb_uart_echo_responder;

  logic       clk;
  logic       n_rst;
  logic       enable;
  logic       rx_flag;
  logic [7:0] rx_data;
  logic       parity_error;
  logic       rx_flag_clr;
  logic [7:0] tx_data;
  logic       tx_send;
  logic [2:0] fifo_count;
  logic [7:0] err_count;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic prev_send = 1'b0;

  uart_echo_responder dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .rx_flag      (rx_flag),
    .rx_data      (rx_data),
    .parity_error (parity_error),
    .rx_flag_clr  (rx_flag_clr),
    .tx_data      (tx_data),
    .tx_send      (tx_send),
    .fifo_count   (fifo_count),
    .err_count    (err_count),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    prev_send = tx_send;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input int maxc, output int cyc,
                           output logic [7:0] d);
    cyc = -1;
    d   = 8'h00;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (tx_send && !prev_send) begin
        cyc = i;
        d   = tx_data;
        break;
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic par);
    rx_flag      = 1'b1;
    rx_data      = d;
    parity_error = par;
    tick();
    rx_flag      = 1'b0;
    parity_error = 1'b0;
    tick();
  endtask

  int         cyc;
  logic [7:0] d;
  int         cnt;

  initial begin
    n_rst        = 1'b0;
    enable       = 1'b0;
    rx_flag      = 1'b0;
    rx_data      = 8'h00;
    parity_error = 1'b0;
    repeat (3) tick();
    check("rst_send", tx_send, 0);
    check("rst_clr", rx_flag_clr, 0);
    check("rst_fifo", fifo_count, 0);
    check("rst_err", err_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_data", tx_data, 0);
    n_rst  = 1'b1;
    enable = 1'b1;
    repeat (3) tick();

    // single echo
    rx_flag = 1'b1;
    rx_data = 8'h55;
    tick();
    check("e_clr0", rx_flag_clr, 1);
    check("e_fifo0", fifo_count, 1);
    check("e_send0", tx_send, 0);
    tick();
    check("e_send1", tx_send, 1);
    check("e_data1", tx_data, 8'h55);
    check("e_fifo1", fifo_count, 0);
    check("e_clr1", rx_flag_clr, 1);
    tick();
    check("e_send2", tx_send, 1);
    check("e_clr2", rx_flag_clr, 1);
    rx_flag = 1'b0;
    tick();
    check("e_clr3", rx_flag_clr, 0);
    check("e_send3", tx_send, 0);
    check("e_data3", tx_data, 8'h55);
    check("e_err", err_count, 0);
    repeat (70) tick();

    // parity discard
    rx_flag      = 1'b1;
    rx_data      = 8'hA3;
    parity_error = 1'b1;
    tick();
    check("p_clr", rx_flag_clr, 1);
    check("p_err", err_count, 1);
    check("p_fifo", fifo_count, 0);
    rx_flag      = 1'b0;
    parity_error = 1'b0;
    tick();
    check("p_clr_off", rx_flag_clr, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_send) cnt++;
    end
    check("p_nosend", cnt, 0);

    // overflow
    enable = 1'b0;
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b0);
    check("o_fifo", fifo_count, 4);
    check("o_drop", drop_count, 1);
    enable = 1'b1;
    wait_rise(5, cyc, d);
    check("o_lat0", cyc, 1);
    check("o_d0", d, 8'h01);
    for (int k = 2; k <= 4; k++) begin
      wait_rise(100, cyc, d);
      check("o_gap", cyc, 62);
      check("o_dat", d, 8'(k));
    end
    wait_rise(100, cyc, d);
    check("o_none", cyc, -1);

    // sticky flag
    enable  = 1'b0;
    rx_flag = 1'b1;
    rx_data = 8'h77;
    cnt     = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rx_flag_clr) cnt++;
    end
    check("s_clr_cnt", cnt, 20);
    check("s_fifo", fifo_count, 1);
    rx_flag = 1'b0;
    tick();
    check("s_clr_off", rx_flag_clr, 0);
    enable = 1'b1;
    wait_rise(5, cyc, d);
    check("s_lat", cyc, 1);
    check("s_dat", d, 8'h77);
    wait_rise(100, cyc, d);
    check("s_once", cyc, -1);

    // simultaneous push and pop
    enable = 1'b0;
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    check("pp_pre", fifo_count, 2);
    enable  = 1'b1;
    rx_flag = 1'b1;
    rx_data = 8'h33;
    tick();
    check("pp_fifo", fifo_count, 2);
    check("pp_send", tx_send, 1);
    check("pp_d0", tx_data, 8'h11);
    rx_flag = 1'b0;
    wait_rise(100, cyc, d);
    check("pp_gap1", cyc, 62);
    check("pp_d1", d, 8'h22);
    wait_rise(100, cyc, d);
    check("pp_gap2", cyc, 62);
    check("pp_d2", d, 8'h33);
    wait_rise(100, cyc, d);
    check("pp_none", cyc, -1);

    // reset mid-send
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h41 + i), 1'b0);
    check("r_pre", fifo_count, 4);
    enable = 1'b1;
    tick();
    check("r_send", tx_send, 1);
    check("r_fifo3", fifo_count, 3);
    n_rst = 1'b0;
    tick();
    check("r_send0", tx_send, 0);
    check("r_fifo0", fifo_count, 0);
    check("r_err0", err_count, 0);
    check("r_drop0", drop_count, 0);
    check("r_data0", tx_data, 0);
    check("r_clr0", rx_flag_clr, 0);
    n_rst = 1'b1;
    wait_rise(100, cyc, d);
    check("r_quiet", cyc, -1);
    check("r_fifo_end", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
